// File: rtl/thermal_pkg.sv
// Shared types and helpers for the thermal sensor scanner.
package thermal_pkg;

    localparam int DEF_TEMP_WIDTH = 12;
    localparam int SAT_W          = 32;

    // Wide enough for any supported reading width; slice to the width in use.
    localparam logic [SAT_W-1:0] FAULT_TEMP = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_START,
        S_WAIT
    } scan_state_e;

    // raw is zero-extended and offset sign-extended to SAT_W by the caller.
    // Two guard bits keep the sign and the overflow separate.
    function automatic logic [SAT_W-1:0] sat_add_offset(
        input logic [SAT_W-1:0] raw,
        input logic [SAT_W-1:0] offset,
        input int               width
    );
        logic [SAT_W+1:0] sum;
        logic [SAT_W+1:0] max_v;
        sum   = {2'b00, raw} + {{2{offset[SAT_W-1]}}, offset};
        max_v = '0;
        for (int i = 0; i < SAT_W; i++)
            if (i < width) max_v[i] = 1'b1;
        if (sum[SAT_W+1]) return '0;
        if (sum > max_v)  return max_v[SAT_W-1:0];
        return sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/thermal_cal_sat.sv
// Offset-add-and-clamp for one raw ADC reading; shared by all zones.
module thermal_cal_sat import thermal_pkg::*; #(
    parameter int TEMP_WIDTH = DEF_TEMP_WIDTH
) (
    input  logic [TEMP_WIDTH-1:0] raw,
    input  logic [TEMP_WIDTH-1:0] offset,
    output logic [TEMP_WIDTH-1:0] corrected
);

    logic [SAT_W-1:0] raw_x;
    logic [SAT_W-1:0] off_x;

    assign raw_x     = SAT_W'(raw);
    assign off_x     = SAT_W'($signed(offset));
    assign corrected = TEMP_WIDTH'(sat_add_offset(raw_x, off_x, TEMP_WIDTH));

endmodule

// File: rtl/thermal_sensor_scanner.sv
// Round-robin scanner: one shared ADC, per-zone calibrated and saturated readings,
// timeout faults reported as maximum temperature.
module thermal_sensor_scanner import thermal_pkg::*; #(
    parameter  int NUM_ZONES      = 4,
    parameter  int TEMP_WIDTH     = DEF_TEMP_WIDTH,
    parameter  int SCAN_INTERVAL  = 1024,
    parameter  int SETTLE_CYCLES  = 8,
    parameter  int TIMEOUT_CYCLES = 255,
    localparam int ZW             = $clog2(NUM_ZONES)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable,
    input  logic                            om_pulse,
    input  logic [NUM_ZONES*TEMP_WIDTH-1:0] cal_offset,
    output logic [ZW-1:0]                   adc_sel,
    output logic                            adc_start,
    input  logic                            adc_done,
    input  logic [TEMP_WIDTH-1:0]           adc_data,
    output logic [NUM_ZONES*TEMP_WIDTH-1:0] zone_temps,
    output logic [NUM_ZONES-1:0]            temp_valid,
    output logic [NUM_ZONES-1:0]            sensor_fault,
    output logic                            round_done
);

    localparam int IW = $clog2(SCAN_INTERVAL + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IW-1:0] INT_LAST  = IW'(SCAN_INTERVAL - 1);
    localparam logic [SW-1:0] SET_LAST  = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [ZW-1:0] ZONE_LAST = ZW'(NUM_ZONES - 1);

    scan_state_e state, state_n;

    logic [IW-1:0] int_cnt;
    logic [SW-1:0] set_cnt;
    logic [TW-1:0] to_cnt;
    logic [ZW-1:0] zone;

    logic [NUM_ZONES-1:0][TEMP_WIDTH-1:0] temps_q;
    logic [TEMP_WIDTH-1:0]                corr;

    logic conv_ok, conv_to, conv_end, round_end, round_go;

    thermal_cal_sat #(.TEMP_WIDTH(TEMP_WIDTH)) u_cal (
        .raw       (adc_data),
        .offset    (cal_offset[zone*TEMP_WIDTH +: TEMP_WIDTH]),
        .corrected (corr)
    );

    // Done beats timeout when both land on the same WAIT cycle.
    assign conv_ok   = (state == S_WAIT) && adc_done;
    assign conv_to   = (state == S_WAIT) && !adc_done && (to_cnt == TO_LAST);
    assign conv_end  = conv_ok || conv_to;
    assign round_end = conv_end && ((zone == ZONE_LAST) || !enable);
    assign round_go  = (state == S_IDLE) && enable && ((int_cnt == INT_LAST) || om_pulse);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (round_go) state_n = S_SETTLE;
            S_SETTLE: if (set_cnt == SET_LAST) state_n = S_START;
            S_START:  state_n = S_WAIT;
            S_WAIT:   if (conv_end) state_n = round_end ? S_IDLE : S_SETTLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Preloading the interval counter makes the first enabled cycle start a round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_cnt    <= INT_LAST;
            set_cnt    <= '0;
            to_cnt     <= '0;
            zone       <= '0;
            adc_sel    <= '0;
            adc_start  <= 1'b0;
            round_done <= 1'b0;
        end else begin
            adc_start  <= (state_n == S_START);
            round_done <= round_end;
            case (state)
                S_IDLE: begin
                    if (round_go) begin
                        int_cnt <= '0;
                        zone    <= '0;
                        adc_sel <= '0;
                        set_cnt <= '0;
                    end else if (enable) begin
                        int_cnt <= int_cnt + 1'b1;
                    end
                end
                S_SETTLE: set_cnt <= set_cnt + 1'b1;
                S_START:  to_cnt  <= '0;
                S_WAIT: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (conv_end && !round_end) begin
                        zone    <= zone + 1'b1;
                        adc_sel <= zone + 1'b1;
                        set_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            temps_q      <= '0;
            temp_valid   <= '0;
            sensor_fault <= '0;
        end else begin
            for (int z = 0; z < NUM_ZONES; z++) begin
                temp_valid[z] <= conv_end && (zone == ZW'(z));
                if (conv_end && (zone == ZW'(z))) begin
                    temps_q[z]      <= conv_ok ? corr : FAULT_TEMP[TEMP_WIDTH-1:0];
                    sensor_fault[z] <= !conv_ok;
                end
            end
        end
    end

    assign zone_temps = temps_q;

endmodule

// File: tb/tb_thermal_sensor_scanner.sv
// Directed bench for thermal_sensor_scanner with a behavioural ADC responder.
module tb_thermal_sensor_scanner;

    localparam int NZ = 4;
    localparam int W  = 12;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            enable = 1'b0;
    logic            om_pulse = 1'b0;
    logic [NZ*W-1:0] cal_offset = '0;
    logic [1:0]      adc_sel;
    logic            adc_start;
    logic            adc_done = 1'b0;
    logic [W-1:0]    adc_data = '0;
    logic [NZ*W-1:0] zone_temps;
    logic [NZ-1:0]   temp_valid;
    logic [NZ-1:0]   sensor_fault;
    logic            round_done;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    int           adc_dly [NZ];
    logic [W-1:0] adc_val [NZ];
    int           start_sel_q [$];
    int           rz;

    thermal_sensor_scanner dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .om_pulse     (om_pulse),
        .cal_offset   (cal_offset),
        .adc_sel      (adc_sel),
        .adc_start    (adc_start),
        .adc_done     (adc_done),
        .adc_data     (adc_data),
        .zone_temps   (zone_temps),
        .temp_valid   (temp_valid),
        .sensor_fault (sensor_fault),
        .round_done   (round_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] slot(input int z);
        return zone_temps[z*W +: W];
    endfunction

    task automatic wait_valid(input int budget, output int z, output int at);
        bit seen = 1'b0;
        z  = -1;
        at = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (temp_valid != '0) begin
                seen = 1'b1;
                at   = cyc;
                for (int k = 0; k < NZ; k++) if (temp_valid[k]) z = k;
            end
        end
        chk("valid_seen", 64'(seen), 64'd1);
    endtask

    task automatic wait_start(input int budget, output int at);
        bit seen = 1'b0;
        at = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (adc_start) begin
                seen = 1'b1;
                at   = cyc;
            end
        end
        chk("start_seen", 64'(seen), 64'd1);
    endtask

    task automatic pulse_om();
        om_pulse = 1'b1;
        @(negedge clk);
        om_pulse = 1'b0;
    endtask

    // ADC model: answers each start after adc_dly cycles; 0 means never answer.
    initial begin
        forever begin
            @(negedge clk);
            if (adc_start) begin
                rz = int'(adc_sel);
                start_sel_q.push_back(rz);
                if (adc_dly[rz] > 0) begin
                    repeat (adc_dly[rz]) @(negedge clk);
                    adc_done = 1'b1;
                    adc_data = adc_val[rz];
                    @(negedge clk);
                    adc_done = 1'b0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        int z, at, e0, prev, v2, t1, s0, n_st, n_vl;
        logic [15:0] sel_word;

        for (int i = 0; i < NZ; i++) begin
            adc_dly[i] = 3;
            adc_val[i] = 12'h800;
        end

        repeat (3) @(negedge clk);
        chk("reset_outputs", {zone_temps, temp_valid, sensor_fault, adc_sel, adc_start, round_done}, '0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_disabled", {adc_start, temp_valid, round_done}, '0);

        // Normal round: 0x800 everywhere, 12-cycle zone spacing.
        start_sel_q.delete();
        enable = 1'b1;
        e0     = cyc;
        prev   = e0;
        for (int k = 0; k < NZ; k++) begin
            wait_valid(100, z, at);
            chk("norm_zone", 64'(z), 64'(k));
            chk("norm_data", slot(k), 12'h800);
            chk("norm_round_done", round_done, (k == NZ - 1));
            chk("norm_spacing", 64'(at - prev), (k == 0) ? 64'd13 : 64'd12);
            prev = at;
        end
        sel_word = '0;
        foreach (start_sel_q[i]) sel_word = {sel_word[11:0], 4'(start_sel_q[i])};
        chk("norm_sel_seq", {start_sel_q.size(), sel_word}, {32'd4, 16'h0123});

        // om_pulse at interval count 10, saturation data, om_pulse in WAIT ignored.
        cal_offset = {12'h001, 12'hFF0, 12'hFE0, 12'h020};
        adc_val[0] = 12'hFF0;
        adc_val[1] = 12'h010;
        adc_val[2] = 12'h100;
        adc_val[3] = 12'h7FF;
        repeat (10) @(negedge clk);
        pulse_om();
        wait_start(50, at);
        chk("om_start_latency", 64'(at - prev), 64'd19);
        wait_valid(100, z, at);
        chk("sat_hi", slot(0), 12'hFFF);
        wait_start(50, at);
        @(negedge clk);
        pulse_om();
        wait_valid(100, z, at);
        chk("sat_lo", slot(1), 12'h000);
        wait_valid(100, z, at);
        chk("sat_mid", slot(2), 12'h0F0);
        wait_valid(100, z, at);
        chk("sat_pass", slot(3), 12'h800);
        chk("sat_no_fault", sensor_fault, 4'b0000);
        v2 = at;

        // Next round self-starts after the full interval; zone 2 times out.
        cal_offset = '0;
        adc_dly[2] = 0;
        adc_val[0] = 12'h111;
        adc_val[1] = 12'h222;
        adc_val[3] = 12'h333;
        wait_start(1100, at);
        chk("interval_start", 64'(at - v2), 64'd1032);
        wait_valid(100, z, at);
        wait_valid(100, z, at);
        t1 = at;
        wait_valid(400, z, at);
        chk("to_zone", 64'(z), 64'd2);
        chk("to_latency", 64'(at - t1), 64'd264);
        chk("to_data", slot(2), 12'hFFF);
        chk("to_fault", sensor_fault, 4'b0100);
        chk("to_other_slot", slot(3), 12'h800);
        wait_valid(100, z, at);
        chk("to_next_zone", 64'(z), 64'd3);
        chk("to_next_data", slot(3), 12'h333);
        chk("fault_sticky", sensor_fault, 4'b0100);

        // Zone 2 recovers on its next good conversion.
        adc_dly[2] = 3;
        adc_val[2] = 12'h400;
        pulse_om();
        wait_valid(100, z, at);
        wait_valid(100, z, at);
        wait_valid(100, z, at);
        chk("recover_data", slot(2), 12'h400);
        chk("recover_fault", sensor_fault, 4'b0000);
        wait_valid(100, z, at);

        // Done arriving on the timeout cycle wins.
        adc_dly[0] = 255;
        adc_val[0] = 12'h321;
        pulse_om();
        wait_start(50, s0);
        wait_valid(400, z, at);
        chk("coll_zone", 64'(z), 64'd0);
        chk("coll_latency", 64'(at - s0), 64'd256);
        chk("coll_data", slot(0), 12'h321);
        chk("coll_fault", sensor_fault, 4'b0000);
        for (int k = 1; k < NZ; k++) wait_valid(100, z, at);

        // Enable dropped during zone 1 WAIT.
        adc_dly[0] = 3;
        adc_val[0] = 12'h111;
        adc_dly[1] = 5;
        pulse_om();
        wait_valid(100, z, at);
        wait_start(50, at);
        @(negedge clk);
        enable = 1'b0;
        wait_valid(100, z, at);
        chk("drop_zone", 64'(z), 64'd1);
        chk("drop_round_done", round_done, 1'b1);
        n_st = 0;
        n_vl = 0;
        om_pulse = 1'b1;
        repeat (60) begin
            @(negedge clk);
            n_st += int'(adc_start);
            n_vl += int'(temp_valid != '0);
        end
        om_pulse = 1'b0;
        chk("drop_no_start", 64'(n_st), 64'd0);
        chk("drop_no_valid", 64'(n_vl), 64'd0);

        // Asynchronous reset in WAIT, then first round on first enabled cycle.
        enable = 1'b1;
        pulse_om();
        wait_start(50, at);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", {zone_temps, temp_valid, sensor_fault, adc_sel, adc_start, round_done}, '0);
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        enable = 1'b1;
        e0 = cyc;
        wait_start(50, at);
        chk("post_reset_first_start", 64'(at - e0), 64'd9);
        wait_valid(100, z, at);
        chk("post_reset_data", slot(0), 12'h111);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
